uart_recv: RTL and testbench

UART receiver for the Nexys4DDR USB-UART bridge. Fixed 8N1 format at 115200 baud from the 100 MHz board clock.
- Recovers bytes from the FTDI TX line (UART_TXD_IN).
- Presents each good byte with a one-cycle valid strobe.
- Flags framing errors on a bad stop bit.
- Counterpart to the team's UART transmitter; feeds host-to-FPGA command/weight loading.

---
 rtl/uart_recv.sv | 184 ++++++++++++++++++
 tb/tb_uart_recv.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver for the Nexys4DDR USB-UART bridge (115200 baud
// from the 100 MHz board clock). Recovers bytes from UART_TXD_IN, strobes
// valid for one cycle per good byte, and strobes frame_err on a low stop bit.
// Compile-time option: define UART_RECV_PARITY_EN for 8E1 framing, which adds
// a PARITY state and the parity_err output.
`timescale 1ns/1ps

module uart_recv #(
    parameter int unsigned BAUD_COUNT = 868,
    parameter int unsigned HALF_COUNT = BAUD_COUNT / 2
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       UART_TXD_IN,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
`ifdef UART_RECV_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RECV_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [9:0] HALF_TGT = 10'(HALF_COUNT - 1);
    localparam logic [9:0] BAUD_TGT = 10'(BAUD_COUNT - 1);

    logic       sync1_q;
    logic       rx_s_q;
    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       sample;
`ifdef UART_RECV_PARITY_EN
    logic       par_q, par_d;
    logic       perr_q, perr_d;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= UART_TXD_IN;
            rx_s_q  <= sync1_q;
        end
    end

    // State register plus the datapath registers that move with it.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RECV_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RECV_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Sample point: mid start bit in START, one full bit period elsewhere.
    always_comb begin
        sample = 1'b0;
        case (state_q)
            S_START: sample = (cnt_q == HALF_TGT);
            S_DATA,
`ifdef UART_RECV_PARITY_EN
            S_PARITY,
`endif
            S_STOP:  sample = (cnt_q == BAUD_TGT);
            default: sample = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!rx_s_q) state_d = S_START;
            S_START: if (sample)  state_d = rx_s_q ? S_IDLE : S_DATA;
            S_DATA: begin
                if (sample && idx_q == 3'd7) begin
`ifdef UART_RECV_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RECV_PARITY_EN
            S_PARITY: if (sample) state_d = S_STOP;
`endif
            S_STOP:  if (sample)  state_d = rx_s_q ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s_q)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic. The baud counter restarts on each state
    // entry and after every sample so DATA can reuse it bit after bit.
    always_comb begin
        cnt_d   = cnt_q + 10'd1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RECV_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (state_d != state_q || sample || state_q == S_IDLE || state_q == S_BREAK)
            cnt_d = '0;
        case (state_q)
            S_START: idx_d = '0;
            S_DATA: begin
                if (sample) begin
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q != 3'd7)
                        idx_d = idx_q + 3'd1;
                end
            end
`ifdef UART_RECV_PARITY_EN
            S_PARITY: if (sample) par_d = rx_s_q;
`endif
            S_STOP: begin
                if (sample) begin
                    if (!rx_s_q)
                        ferr_d = 1'b1;
`ifdef UART_RECV_PARITY_EN
                    else if ((^shift_q) ^ par_q)
                        perr_d = 1'b1;
`endif
                    else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);
`ifdef UART_RECV_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: scoreboard bench for uart_recv. The receiver runs at a reduced
// bit period (200 cycles) to keep run time short; sender-rate offsets and the
// glitch width are scaled by the same ratio as the 868-cycle case.
`timescale 1ns/1ps

module tb_uart_recv;

    localparam int B   = 200;
    localparam int H   = B / 2;
    localparam int LAT = 2 + H + 9 * B;

    typedef struct {
        int         kind;     // 0 valid, 1 frame_err, 2 parity_err
        logic [7:0] d;
        bit         lat;
        int         t0;
        int         lat_exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       line;
    logic [7:0] data;
    logic       valid, frame_err, busy, perr;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    exp_t       sb[$];
    logic [7:0] rb = 8'hC3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_recv #(.BAUD_COUNT(B)) dut (
        .CLK100MHZ  (clk),
        .reset      (reset),
        .UART_TXD_IN(line),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
`ifdef UART_RECV_PARITY_EN
        .parity_err (perr),
`endif
        .busy       (busy)
    );
`ifndef UART_RECV_PARITY_EN
    assign perr = 1'b0;
`endif

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at the current negedge; kind<0 queues nothing.
    task automatic send(input logic [7:0] b, input int per, input bit stop,
                        input bit pen, input bit pb, input int kind,
                        input logic [7:0] ed, input bit lat);
        exp_t e;
        line = 1'b0;
        if (kind >= 0) begin
            e.kind = kind; e.d = ed; e.lat = lat; e.t0 = cyc;
            e.lat_exp = LAT + (pen ? B : 0);
            sb.push_back(e);
        end
        hold(per);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            hold(per);
        end
        if (pen) begin
            line = pb;
            hold(per);
        end
        line = stop;
        hold(per);
    endtask

    // Monitor: every output pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && (valid || frame_err || perr)) begin
            int   k;
            exp_t e;
            k = valid ? 0 : (frame_err ? 1 : 2);
            chk("pulse_exclusive", (32'(valid) + 32'(frame_err) + 32'(perr)) == 1,
                {29'd0, valid, frame_err, perr}, 0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 1'b0, k, -1);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", k == e.kind, k, e.kind);
                chk("pulse_data", data == e.d, int'(data), int'(e.d));
                if (e.lat)
                    chk("latency", (cyc - e.t0 >= e.lat_exp - 1) && (cyc - e.t0 <= e.lat_exp + 1),
                        cyc - e.t0, e.lat_exp);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        line  = 1'b1;
        hold(4);
        chk("rst_data", data == 8'h00, int'(data), 0);
        chk("rst_valid", valid == 1'b0, int'(valid), 0);
        chk("rst_frame_err", frame_err == 1'b0, int'(frame_err), 0);
        chk("rst_busy", busy == 1'b0, int'(busy), 0);
        reset = 1'b0;
        hold(10);

        // Good frame with latency check.
        send(8'hA5, B, 1'b1, 1'b0, 1'b0, 0, 8'hA5, 1'b1);
        hold(20);
        chk("busy_after_a5", busy == 1'b0, int'(busy), 0);

        // Short glitch: rejected at mid start bit.
        line = 1'b0;
        hold(10);
        chk("busy_on_glitch", busy == 1'b1, int'(busy), 1);
        hold(36);
        line = 1'b1;
        hold(H + 5 - 46);
        chk("busy_after_glitch", busy == 1'b0, int'(busy), 0);
        hold(B);

        // Bad stop bit, line held low three more bit times.
        send(8'h3C, B, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 1'b0);
        hold(3 * B);
        line = 1'b1;
        hold(20);
        chk("data_hold_after_ferr", data == 8'hA5, int'(data), 8'hA5);
        chk("busy_after_break", busy == 1'b0, int'(busy), 0);
        send(8'h81, B, 1'b1, 1'b0, 1'b0, 0, 8'h81, 1'b1);
        hold(20);

        // Back-to-back frames, sender -3% then +3%.
        send(8'h00, 194, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        send(8'hFF, 194, 1'b1, 1'b0, 1'b0, 0, 8'hFF, 1'b0);
        send(8'h55, 194, 1'b1, 1'b0, 1'b0, 0, 8'h55, 1'b0);
        hold(B);
        send(8'h00, 206, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        send(8'hFF, 206, 1'b1, 1'b0, 1'b0, 0, 8'hFF, 1'b0);
        send(8'h55, 206, 1'b1, 1'b0, 1'b0, 0, 8'h55, 1'b0);
        hold(B);

        // Reset in the middle of bit 4.
        line = 1'b0;
        hold(B);
        for (int i = 0; i < 4; i++) begin
            line = rb[i];
            hold(B);
        end
        line = rb[4];
        hold(H);
        reset = 1'b1;
        hold(3);
        chk("data_in_reset", data == 8'h00, int'(data), 0);
        chk("busy_in_reset", busy == 1'b0, int'(busy), 0);
        line = 1'b1;
        hold(3);
        reset = 1'b0;
        hold(2 * B);
        chk("data_after_abort", data == 8'h00, int'(data), 0);
        send(8'h7E, B, 1'b1, 1'b0, 1'b0, 0, 8'h7E, 1'b1);
        hold(B);

`ifdef UART_RECV_PARITY_EN
        send(8'hA5, B, 1'b1, 1'b1, 1'b0, 0, 8'hA5, 1'b1);
        hold(20);
        send(8'h3C, B, 1'b1, 1'b1, 1'b1, 2, 8'hA5, 1'b0);
        hold(B);
`endif

        hold(2 * B);
        chk("scoreboard_drained", sb.size() == 0, sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
